// File: rtl/tl_arb_pkg.sv
// Shared types and default parameters for the tl_arbiter codebase slice.
package tl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick over four requesters, starting at last_grant+1.
// With TL_ARB_PRIORITY_EN defined, requester 0 wins whenever it requests.
module rr_pick
  import tl_arb_pkg::*;
(
  input  logic [DEF_NUM_CH-1:0] req,
  input  logic [1:0]            last_grant,
  output logic [1:0]            grant,
  output logic                  valid
);

  logic [1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    // Walk from lowest to highest priority; later hits overwrite earlier ones.
    for (int k = DEF_NUM_CH; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
`ifdef TL_ARB_PRIORITY_EN
    if (req[0]) begin
      grant = 2'd0;
      valid = 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/tl_arbiter.sv
// Burst arbiter draining four channel FIFOs into one downstream FIFO.
// Optional channel-0 priority is selected with TL_ARB_PRIORITY_EN (see rr_pick).
module tl_arbiter
  import tl_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int BURST  = DEF_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH-1:0]        fifo_almost_empty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_pop,
  input  logic                     out_almost_full,
  input  logic                     out_full,
  output logic                     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               active_ch,
  output logic                     idle
);

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  state_t            state_q, state_d;
  logic [1:0]        active_q, active_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] pop_q, pop_d;
  logic              rd_vld_q;
  logic [1:0]        rd_ch_q;
  logic              out_push_q;
  logic [DATA_W-1:0] out_data_q;

  logic [NUM_CH-1:0] elig;
  logic [1:0]        rr_base;
  logic [1:0]        pick_ch;
  logic              pick_vld;
  logic              grant_done;
  logic              launch;
  logic [DATA_W-1:0] ch_word [NUM_CH];

  // Full-at-push is a downstream error; the word is still driven regardless.
  logic unused_full;
  assign unused_full = out_full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_word
    assign ch_word[i] = fifo_data[i*DATA_W +: DATA_W];
  end

  // A channel whose last word is already being popped must not be popped again.
  assign elig    = ~fifo_empty & ~(pop_q & fifo_almost_empty);
  assign rr_base = (state_q == IDLE) ? last_grant_q : active_q;

  rr_pick u_pick (
    .req        (elig),
    .last_grant (rr_base),
    .grant      (pick_ch),
    .valid      (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pop_d        = '0;
    launch       = 1'b0;
    grant_done   = !elig[active_q] || (cnt_q >= BURST_CNT);

    case (state_q)
      IDLE: launch = 1'b1;
      GRANT: begin
        if (grant_done) begin
          last_grant_d = active_q;
          launch       = 1'b1;
        end else if (out_almost_full) begin
          state_d = PAUSE;
        end else begin
          pop_d[active_q] = 1'b1;
          if (cnt_q < BURST_CNT) cnt_d = cnt_q + 4'd1;
        end
      end
      PAUSE: if (!out_almost_full) state_d = GRANT;
      default: state_d = IDLE;
    endcase

    // A new grant pops in the same decision, so consecutive grants leave no gap.
    if (launch) begin
      if (pick_vld && !out_almost_full) begin
        state_d        = GRANT;
        active_d       = pick_ch;
        cnt_d          = 4'd1;
        pop_d[pick_ch] = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      active_q     <= 2'd0;
      last_grant_q <= 2'd3;
      cnt_q        <= '0;
      pop_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_ch_q      <= 2'd0;
      out_push_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q      <= state_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      pop_q        <= pop_d;
      rd_vld_q     <= |pop_q;
      rd_ch_q      <= active_q;
      out_push_q   <= rd_vld_q;
      if (rd_vld_q) out_data_q <= ch_word[rd_ch_q];
    end
  end

  assign fifo_pop  = pop_q;
  assign out_push  = out_push_q;
  assign out_data  = out_data_q;
  assign active_ch = active_q;
  assign idle      = (state_q == IDLE) && !(|pop_q) && !rd_vld_q;

endmodule

// File: tb/tb_tl_arbiter.sv
// Scoreboard bench for tl_arbiter: directed loads, hand-ordered expected pushes.
`timescale 1ns/1ps
module tb_tl_arbiter;
  import tl_arb_pkg::*;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 4;
  localparam int BURST  = 4;
  localparam int LIMIT  = 300;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH-1:0]        fifo_almost_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        fifo_pop;
  logic                     out_almost_full;
  logic                     out_full;
  logic                     out_push;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               active_ch;
  logic                     idle;

  tl_arbiter #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .BURST(BURST)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data         (fifo_data),
    .fifo_pop          (fifo_pop),
    .out_almost_full   (out_almost_full),
    .out_full          (out_full),
    .out_push          (out_push),
    .out_data          (out_data),
    .active_ch         (active_ch),
    .idle              (idle)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq [NUM_CH][$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                cyc;
  int                n_pass;
  int                n_check;
  int                pop_cnt [NUM_CH];
  int                run_len;
  int                last_pop_cyc;
  logic [NUM_CH-1:0] pop_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] word(input int ch, input int idx);
    return DATA_W'((ch + 1) * 256 + idx);
  endfunction

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(word(ch, i));
  endtask

  task automatic expect_words(input int ch, input int first, input int n);
    for (int i = first; i < first + n; i++) exp_q.push_back(word(ch, i));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    out_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, 32'(n < LIMIT), 1);
    @(negedge clk);
    check({name, "_idle_after"}, 32'(idle), 1);
  endtask

  // Downstream-facing FIFO model: pops seen in a cycle take effect at the next edge.
  initial begin
    fifo_empty        = '1;
    fifo_almost_empty = '1;
    fifo_data         = '0;
    forever begin
      @(negedge clk);
      pop_s = fifo_pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_s[i]) begin
          check("pop_of_nonempty_fifo", 32'(fq[i].size() > 0), 1);
          if (fq[i].size() > 0) fifo_data[i*DATA_W +: DATA_W] = fq[i].pop_front();
        end
        fifo_empty[i]        = (fq[i].size() == 0);
        fifo_almost_empty[i] = (fq[i].size() <= 1);
      end
    end
  end

  // Monitor: records pop times and checks each push against the scoreboard.
  initial begin
    cyc          = 0;
    run_len      = 0;
    last_pop_cyc = -10;
    for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        exp_cyc_q.delete();
      end else begin
        if (fifo_pop != '0) begin
          check("pop_onehot", 32'($onehot(fifo_pop)), 1);
          for (int i = 0; i < NUM_CH; i++) if (fifo_pop[i]) pop_cnt[i]++;
          run_len      = (last_pop_cyc == cyc - 1) ? run_len + 1 : 1;
          last_pop_cyc = cyc;
          exp_cyc_q.push_back(cyc + 2);
        end
        if (out_push) begin
          if (out_full) check("push_while_full", 32'(out_full), 0);
          check("push_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("push_data", 32'(out_data), 32'(exp_q.pop_front()));
          check("push_has_pop", 32'(exp_cyc_q.size() > 0), 1);
          if (exp_cyc_q.size() > 0) check("push_latency", cyc, exp_cyc_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int n;
    int p0, p1, p2, p3;
    int pops;
    int pushes;

    n_pass          = 0;
    n_check         = 0;
    reset           = 1'b1;
    out_almost_full = 1'b0;
    out_full        = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_fifo_pop", 32'(fifo_pop), 0);
    check("rst_out_push", 32'(out_push), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_active_ch", 32'(active_ch), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_last_grant", 32'(dut.last_grant_q), 3);
    check("rst_burst_cnt", 32'(dut.cnt_q), 0);
    reset = 1'b0;

    // ch1 holds three words
    reset_dut();
    p1 = pop_cnt[1];
    fq[1].push_back(12'h111);
    fq[1].push_back(12'h112);
    fq[1].push_back(12'h113);
    exp_q.push_back(12'h111);
    exp_q.push_back(12'h112);
    exp_q.push_back(12'h113);
    wait_done("single_ch");
    check("single_ch_pops", pop_cnt[1] - p1, 3);
    check("single_ch_contiguous", run_len, 3);

    // All channels hold six words: two rounds of strict rotation
    reset_dut();
    p0 = pop_cnt[0]; p1 = pop_cnt[1]; p2 = pop_cnt[2]; p3 = pop_cnt[3];
    for (int c = 0; c < NUM_CH; c++) load(c, 6);
    for (int c = 0; c < NUM_CH; c++) expect_words(c, 0, 4);
    for (int c = 0; c < NUM_CH; c++) expect_words(c, 4, 2);
    wait_done("rotation");
    check("rotation_pops",
          (pop_cnt[0] - p0) + (pop_cnt[1] - p1) + (pop_cnt[2] - p2) + (pop_cnt[3] - p3), 24);
    check("rotation_no_gaps", run_len, 24);

    // Backpressure after the second pop of a ch2 burst
    reset_dut();
    p2 = pop_cnt[2]; p3 = pop_cnt[3];
    load(2, 6);
    load(3, 2);
    expect_words(2, 0, 4);
    expect_words(3, 0, 2);
    expect_words(2, 4, 2);
    seen = 0;
    n    = 0;
    while (seen < 2 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (fifo_pop[2]) seen++;
    end
    check("pause_second_pop_seen", seen, 2);
    out_almost_full = 1'b1;
    pops   = 0;
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fifo_pop != '0) pops++;
      if (out_push) pushes++;
    end
    check("pause_no_pops", pops, 0);
    check("pause_inflight_pushes", pushes, 2);
    check("pause_state", 32'(dut.state_q), 32'(PAUSE));
    check("pause_active_ch", 32'(active_ch), 2);
    check("pause_not_idle", 32'(idle), 0);
    out_almost_full = 1'b0;
    wait_done("pause");
    check("pause_ch2_pops", pop_cnt[2] - p2, 6);
    check("pause_ch3_pops", pop_cnt[3] - p3, 2);
    check("pause_resume_contiguous", run_len, 6);

    // Single word with almost_empty: no double pop
    reset_dut();
    p3 = pop_cnt[3];
    load(3, 1);
    expect_words(3, 0, 1);
    wait_done("last_word");
    check("last_word_single_pop", pop_cnt[3] - p3, 1);

    // Reset in the cycle after a pop discards in-flight words
    reset_dut();
    load(1, 3);
    expect_words(1, 2, 1);
    seen = 0;
    n    = 0;
    while (seen < 1 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (fifo_pop[1]) seen++;
    end
    check("midrst_pop_seen", seen, 1);
    @(negedge clk);
    check("midrst_push_before", 32'(out_push), 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_push_in_reset", 32'(out_push), 0);
    check("midrst_fifo_pop", 32'(fifo_pop), 0);
    check("midrst_out_data", 32'(out_data), 0);
    check("midrst_active_ch", 32'(active_ch), 0);
    check("midrst_idle", 32'(idle), 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_push_after", 32'(out_push), 0);
    wait_done("midrst");

    // ch0 and ch3 hold eight words each
    reset_dut();
    load(0, 8);
    load(3, 8);
`ifdef TL_ARB_PRIORITY_EN
    expect_words(0, 0, 8);
    expect_words(3, 0, 8);
`else
    expect_words(0, 0, 4);
    expect_words(3, 0, 4);
    expect_words(0, 4, 4);
    expect_words(3, 4, 4);
`endif
    wait_done("ch0_ch3");
    check("ch0_ch3_contiguous", run_len, 16);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
